// File: rtl/selftrig_fill_reader_if.sv
// Stream handshakes of the fill reader: tagged DDR3 words in, data bursts out.
interface selftrig_fill_reader_if;
  logic [131:0] in_dat;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] out_dat;
  logic [22:0]  out_wfm;
  logic         out_valid;
  logic         out_ready;

  modport master (output in_dat, in_valid, out_ready,
                  input  in_ready, out_dat, out_wfm, out_valid);
  modport slave  (input  in_dat, in_valid, out_ready,
                  output in_ready, out_dat, out_wfm, out_valid);
endinterface

// File: rtl/selftrig_fill_reader.sv
// Parses a DDR3 readback fill (fill hdr, per-trigger wfm hdr + data, checksum),
// forwards data bursts through a single-entry output register and flags errors.
module selftrig_fill_reader (
  input  logic                         clk,
  input  logic                         rst_n,
  selftrig_fill_reader_if.slave        bus,
  output logic                         fill_hdr_valid,
  output logic [23:0]                  fill_num,
  output logic [22:0]                  num_wfms,
  output logic [13:0]                  num_bursts,
  output logic [15:0]                  pre_trig,
  output logic [11:0]                  channel_tag,
  output logic                         wfm_hdr_valid,
  output logic [41:0]                  trig_time,
  output logic [22:0]                  wfm_start_adr,
  output logic                         fill_done,
  output logic                         checksum_ok,
  output logic [4:0]                   err,
  input  logic                         err_clr
);
  localparam int NUM_LANES = 8;
  localparam int VEC_W     = 16;

  typedef enum logic [2:0] {IDLE, WHDR, DATA, CSUM, RESYNC} state_t;
  state_t state, state_nxt;

  logic [3:0]   tag;
  logic [127:0] pl;
  logic         acc;
  assign tag = bus.in_dat[131:128];
  assign pl  = bus.in_dat[127:0];
  assign acc = bus.in_valid && bus.in_ready;

  logic [22:0]  wfm_cnt;
  logic [13:0]  burst_cnt;
  logic [127:0] csum;

  // Tag each state waits for.
  logic [3:0] exp_tag;
  always_comb begin
    exp_tag = 4'd1;
    case (state)
      WHDR:    exp_tag = 4'd2;
      DATA:    exp_tag = 4'd3;
      CSUM:    exp_tag = 4'd4;
      default: exp_tag = 4'd1;
    endcase
  end

  // A tag-1 word always (re)starts a fill, even when it arrives out of place.
  logic tag_bad, do_fhdr, do_whdr, do_data, do_csum;
  assign tag_bad = acc && (state != RESYNC) && (tag != exp_tag);
  assign do_fhdr = acc && (tag == 4'd1);
  assign do_whdr = acc && (state == WHDR) && (tag == 4'd2);
  assign do_data = acc && (state == DATA) && (tag == 4'd3);
  assign do_csum = acc && (state == CSUM) && (tag == 4'd4);

  logic last_burst, more_wfms, wfm_end;
  assign last_burst = ({1'b0, burst_cnt} + 15'd1) == {1'b0, num_bursts};
  assign more_wfms  = ({1'b0, wfm_cnt} + 24'd1) < {1'b0, num_wfms};
  assign wfm_end    = (do_whdr && (num_bursts == 14'd0)) || (do_data && last_burst);

  // Expected fill length in words: header + checksum + per-waveform header and bursts.
  logic [37:0] len_exp;
  logic        len_bad;
  assign len_exp = ({15'd0, pl[98:76]} * ({24'd0, pl[63:50]} + 38'd1)) + 38'd2;
  assign len_bad = len_exp != {15'd0, pl[49:27]};

  // Each sample is a 12-bit value: bits [15:11] must be all zeros or all ones.
  logic sext_bad;
  always_comb begin
    sext_bad = 1'b0;
    for (int i = 0; i < NUM_LANES; i++)
      if ((|pl[i*VEC_W+11 +: 5]) && !(&pl[i*VEC_W+11 +: 5])) sext_bad = 1'b1;
  end

  logic [4:0] err_set;
  assign err_set = {do_data && sext_bad,
                    do_fhdr && len_bad,
                    do_whdr && (pl[71:49] != wfm_cnt),
                    (do_fhdr || do_whdr) && (pl[127:126] != 2'b01),
                    tag_bad};

  // State register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    if (do_fhdr)      state_nxt = (pl[98:76] == 23'd0) ? CSUM : WHDR;
    else if (tag_bad) state_nxt = RESYNC;
    else if (wfm_end) state_nxt = more_wfms ? WHDR : CSUM;
    else if (do_whdr) state_nxt = DATA;
    else if (do_csum) state_nxt = IDLE;
  end

  // Only DATA can be blocked, by a full output register.
  always_comb begin
    bus.in_ready = 1'b1;
    if (state == DATA) bus.in_ready = bus.out_ready || !bus.out_valid;
  end

  // Counters, checksum, header fields, output register and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wfm_cnt        <= '0;
      burst_cnt      <= '0;
      csum           <= '0;
      fill_num       <= '0;
      num_wfms       <= '0;
      num_bursts     <= '0;
      pre_trig       <= '0;
      channel_tag    <= '0;
      trig_time      <= '0;
      wfm_start_adr  <= '0;
      fill_hdr_valid <= 1'b0;
      wfm_hdr_valid  <= 1'b0;
      fill_done      <= 1'b0;
      checksum_ok    <= 1'b0;
      err            <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_dat    <= '0;
      bus.out_wfm    <= '0;
    end else begin
      fill_hdr_valid <= do_fhdr;
      wfm_hdr_valid  <= do_whdr;
      fill_done      <= do_csum;

      if (do_fhdr)      wfm_cnt <= '0;
      else if (wfm_end) wfm_cnt <= wfm_cnt + 23'd1;

      if (do_whdr)      burst_cnt <= '0;
      else if (do_data) burst_cnt <= burst_cnt + 14'd1;

      if (do_fhdr)                csum <= pl;
      else if (do_whdr || do_data) csum <= csum ^ pl;

      if (do_fhdr) begin
        fill_num    <= pl[23:0];
        num_wfms    <= pl[98:76];
        num_bursts  <= pl[63:50];
        pre_trig    <= {pl[102:99], pl[75:64]};
        channel_tag <= pl[121:110];
      end
      if (do_whdr) begin
        trig_time     <= {pl[125:110], pl[97:72]};
        wfm_start_adr <= pl[48:26];
      end
      if (do_csum) checksum_ok <= (pl == csum);

      if (err_clr) err <= '0;
      else         err <= err | err_set;

      if (do_data) begin
        bus.out_valid <= 1'b1;
        bus.out_dat   <= pl;
        bus.out_wfm   <= wfm_cnt;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_selftrig_fill_reader.sv
// Randomized bench: fills are built from a structural description, and the
// expected bursts, header fields, checksum result and errors follow from it.
module tb_selftrig_fill_reader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_clr = 1'b0;
  always #5 clk = ~clk;

  selftrig_fill_reader_if bus();
  logic        fill_hdr_valid, wfm_hdr_valid, fill_done, checksum_ok;
  logic [23:0] fill_num;
  logic [22:0] num_wfms, wfm_start_adr;
  logic [13:0] num_bursts;
  logic [15:0] pre_trig;
  logic [11:0] channel_tag;
  logic [41:0] trig_time;
  logic [4:0]  err;

  selftrig_fill_reader dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .fill_hdr_valid(fill_hdr_valid), .fill_num(fill_num), .num_wfms(num_wfms),
    .num_bursts(num_bursts), .pre_trig(pre_trig), .channel_tag(channel_tag),
    .wfm_hdr_valid(wfm_hdr_valid), .trig_time(trig_time), .wfm_start_adr(wfm_start_adr),
    .fill_done(fill_done), .checksum_ok(checksum_ok), .err(err), .err_clr(err_clr));

  typedef struct {logic [127:0] d; logic [22:0] w;} ob_t;
  typedef struct {logic [23:0] fn; logic [22:0] nw; logic [13:0] nb;
                  logic [15:0] pt; logic [11:0] ct;} fh_t;
  typedef struct {logic [41:0] tt; logic [22:0] adr;} wh_t;

  logic [131:0] stim[$];
  ob_t          exp_q[$];
  fh_t          exp_fh[$];
  wh_t          exp_wh[$];
  logic         exp_done[$];
  logic [4:0]   exp_err;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, n_acc = 0, first_acc = 0, last_acc = 0;
  int rmode = 0;
  bit stall_chk = 1'b1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready pattern, changed just after each rising edge.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (cyc % 3 == 0);
        2:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Observe on the falling edge: what is seen here happens at the next rising edge.
  ob_t mon_o; fh_t mon_f; wh_t mon_h; logic mon_d;
  always @(negedge clk) if (rst_n) begin
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) chk("spurious_out", 128'(1), 128'(0));
      else begin
        mon_o = exp_q.pop_front();
        chk("out_dat", bus.out_dat, mon_o.d);
        chk("out_wfm", 128'(bus.out_wfm), 128'(mon_o.w));
      end
    end
    if (fill_hdr_valid) begin
      if (exp_fh.size() == 0) chk("spurious_fill_hdr", 128'(1), 128'(0));
      else begin
        mon_f = exp_fh.pop_front();
        chk("fill_num", 128'(fill_num), 128'(mon_f.fn));
        chk("num_wfms", 128'(num_wfms), 128'(mon_f.nw));
        chk("num_bursts", 128'(num_bursts), 128'(mon_f.nb));
        chk("pre_trig", 128'(pre_trig), 128'(mon_f.pt));
        chk("channel_tag", 128'(channel_tag), 128'(mon_f.ct));
      end
    end
    if (wfm_hdr_valid) begin
      if (exp_wh.size() == 0) chk("spurious_wfm_hdr", 128'(1), 128'(0));
      else begin
        mon_h = exp_wh.pop_front();
        chk("trig_time", 128'(trig_time), 128'(mon_h.tt));
        chk("wfm_start_adr", 128'(wfm_start_adr), 128'(mon_h.adr));
      end
    end
    if (fill_done) begin
      if (exp_done.size() == 0) chk("spurious_fill_done", 128'(1), 128'(0));
      else begin
        mon_d = exp_done.pop_front();
        chk("checksum_ok", 128'(checksum_ok), 128'(mon_d));
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      if (n_acc == 0) first_acc = cyc;
      last_acc = cyc;
      n_acc++;
    end
    if (stall_chk && bus.in_valid && bus.in_dat[131:128] == 4'd3 &&
        bus.out_valid && !bus.out_ready)
      chk("in_ready_stall", 128'(bus.in_ready), 128'(0));
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] data_word();
    logic [127:0] d;
    logic [11:0]  s;
    for (int i = 0; i < 8; i++) begin
      s = 12'($urandom);
      d[i*16 +: 16] = {{4{s[11]}}, s};
    end
    return d;
  endfunction

  function automatic fh_t fh_of(input logic [127:0] p);
    fh_t f;
    f.fn = p[23:0]; f.nw = p[98:76]; f.nb = p[63:50];
    f.pt = {p[102:99], p[75:64]}; f.ct = p[121:110];
    return f;
  endfunction

  function automatic logic [127:0] mk_fh(input int nw, input int nb, input int len_ofs);
    logic [127:0] p;
    p = rnd128();
    p[127:126] = 2'b01;
    p[98:76]   = 23'(nw);
    p[63:50]   = 14'(nb);
    p[49:27]   = 23'(2 + nw * (1 + nb) + len_ofs);
    return p;
  endfunction

  // Builds one fill; bad_lane_at counts data bursts across the fill, -1 = none.
  task automatic build_fill(input int nw, input int nb, input bit bad_csum, input int len_ofs,
                            input int bad_lane_at, input int bad_idx_wfm, input bit bad_mark);
    logic [127:0] fh, p, d, x;
    wh_t h; ob_t o;
    int k;
    k = 0;
    fh = mk_fh(nw, nb, len_ofs);
    if (len_ofs != 0) exp_err[3] = 1'b1;
    stim.push_back({4'd1, fh});
    exp_fh.push_back(fh_of(fh));
    x = fh;
    for (int wi = 0; wi < nw; wi++) begin
      p = rnd128();
      p[127:126] = (bad_mark && wi == 0) ? 2'b11 : 2'b01;
      if (bad_mark && wi == 0) exp_err[1] = 1'b1;
      p[71:49] = (wi == bad_idx_wfm) ? 23'd5 : 23'(wi);
      if (wi == bad_idx_wfm && wi != 5) exp_err[2] = 1'b1;
      stim.push_back({4'd2, p});
      h.tt = {p[125:110], p[97:72]}; h.adr = p[48:26];
      exp_wh.push_back(h);
      x = x ^ p;
      for (int b = 0; b < nb; b++) begin
        d = data_word();
        if (k == bad_lane_at) begin d[63:48] = 16'h0800; exp_err[4] = 1'b1; end
        stim.push_back({4'd3, d});
        o.d = d; o.w = 23'(wi);
        exp_q.push_back(o);
        x = x ^ d;
        k++;
      end
    end
    if (bad_csum) x[5] = ~x[5];
    stim.push_back({4'd4, x});
    exp_done.push_back(!bad_csum);
  endtask

  // Presents up to n queued words, one per accept; optional idle gaps.
  task automatic send(input int n, input bit gaps);
    logic [131:0] w;
    int to, cnt;
    cnt = 0;
    while (stim.size() > 0 && cnt < n) begin
      w = stim.pop_front();
      cnt++;
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      bus.in_dat = w; bus.in_valid = 1'b1;
      to = 0;
      forever begin
        @(negedge clk);
        if (bus.in_ready) break;
        to++;
        if (to > 500) begin chk("in_ready_timeout", 128'(0), 128'(1)); break; end
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    int to;
    to = 0;
    while ((exp_q.size() > 0 || exp_done.size() > 0 || exp_fh.size() > 0 ||
            exp_wh.size() > 0) && to < 2000) begin
      @(posedge clk); to++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_outs_left"}, 128'(exp_q.size()), 128'(0));
    chk({tag, "_done_left"}, 128'(exp_done.size() + exp_fh.size() + exp_wh.size()), 128'(0));
    chk({tag, "_err"}, 128'(err), 128'(exp_err));
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    exp_err = '0;
    chk("err_clr", 128'(err), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_dat = '0; bus.in_valid = 1'b0; exp_err = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_checksum_ok", 128'(checksum_ok), 128'(0));
    chk("rst_fill_num", 128'(fill_num), 128'(0));
    chk("rst_pulses", 128'({fill_hdr_valid, wfm_hdr_valid, fill_done}), 128'(0));
    chk("rst_in_ready_run", 128'(bus.in_ready), 128'(1));

    // Back-to-back fill at full rate.
    n_acc = 0;
    build_fill(2, 3, 0, 0, -1, -1, 0);
    send(1000, 0);
    drain("basic");
    chk("basic_words", 128'(n_acc), 128'(10));
    chk("basic_cycles", 128'(last_acc - first_acc + 1), 128'(10));

    build_fill(2, 3, 1, 0, -1, -1, 0);
    send(1000, 0);
    drain("bad_csum");

    build_fill(0, $urandom_range(0, 5), 0, 0, -1, -1, 0);
    send(1000, 1);
    drain("empty");
    build_fill(0, 2, 0, 1, -1, -1, 0);
    send(1000, 1);
    drain("empty_len");
    clear_err();

    // Data word where a waveform header belongs, then junk until a fill header.
    stall_chk = 1'b0;
    stim.push_back({4'd1, mk_fh(1, 2, 0)});
    exp_fh.push_back(fh_of(stim[0][127:0]));
    stim.push_back({4'd3, data_word()});
    stim.push_back({4'd2, rnd128()});
    stim.push_back({4'd3, rnd128()});
    stim.push_back({4'd4, rnd128()});
    exp_err[0] = 1'b1;
    build_fill(1, 2, 0, 0, -1, -1, 0);
    send(1000, 1);
    drain("resync");
    stall_chk = 1'b1;
    clear_err();

    // Downstream ready one cycle in three.
    rmode = 1;
    build_fill(2, 4, 0, 0, -1, -1, 0);
    send(1000, 0);
    drain("stall");

    rmode = 0;
    build_fill(2, 3, 0, 0, 1, -1, 0);
    send(1000, 0);
    drain("sext");
    clear_err();
    build_fill(2, 2, 0, 0, -1, 1, 0);
    send(1000, 0);
    drain("wfm_idx");
    clear_err();
    build_fill(1, 1, 0, 0, -1, -1, 1);
    send(1000, 0);
    drain("marker");
    clear_err();

    // Random fills with random ready and gaps.
    rmode = 2;
    for (int r = 0; r < 8; r++) begin
      build_fill($urandom_range(0, 3), $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                 0, -1, -1, 0);
      send(1000, 1);
      drain("random");
    end

    // Reset in the middle of a fill while the output register is stalled.
    rmode = 3;
    build_fill(2, 3, 0, 0, -1, -1, 0);
    send(3, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_out_valid", 128'(bus.out_valid), 128'(1));
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("midrst_in_ready", 128'(bus.in_ready), 128'(1));
    stim.delete(); exp_q.delete(); exp_fh.delete(); exp_wh.delete(); exp_done.delete();
    exp_err = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rmode = 0;
    build_fill(2, 2, 0, 0, -1, -1, 0);
    send(1000, 0);
    drain("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
